// File: rtl/cdb_arb_if.sv
// cdb_arb_if
//   Bundles the execution-unit completion channels and the common data bus
//   seen by cdb_arb.
//
//   Handshake: a channel transfers a result on a clk edge where
//   exu_valid[i] && exu_ready[i]. exu_ready[i] never depends on exu_valid[i].
//   A producer that sees exu_ready[i] low keeps exu_valid[i] and the payload
//   stable until the transfer happens. The CDB side has no backpressure:
//   cdb_valid is a one-cycle broadcast strobe.
//
//   Signals
//     exu_valid/exu_ready      per-channel handshake (NUM_CH bits)
//     exu_tag/rob_idx/data     per-channel payload, channel i at [i*W +: W]
//     flush                    mispredict flush, discards buffered results
//     cdb_valid/tag/rob/data   registered broadcast
//     cdb_ch                   source channel of the broadcast
//     fifo_cnt                 per-channel occupancy, channel i at [i*CNT_W +: CNT_W]
//
//   Modports: master = execution units / flush source, slave = arbiter.
interface cdb_arb_if #(
   parameter int NUM_CH     = 4,
   parameter int TAG_W      = 4,
   parameter int ROB_IDX_W  = 5,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [NUM_CH-1:0]           exu_valid;
   logic [NUM_CH-1:0]           exu_ready;
   logic [NUM_CH*TAG_W-1:0]     exu_tag;
   logic [NUM_CH*ROB_IDX_W-1:0] exu_rob_idx;
   logic [NUM_CH*DATA_W-1:0]    exu_data;
   logic                        flush;
   logic                        cdb_valid;
   logic [TAG_W-1:0]            cdb_tag;
   logic [ROB_IDX_W-1:0]        cdb_rob_idx;
   logic [DATA_W-1:0]           cdb_data;
   logic [CH_W-1:0]             cdb_ch;
   logic [NUM_CH*CNT_W-1:0]     fifo_cnt;

   modport master (
      output exu_valid, exu_tag, exu_rob_idx, exu_data, flush,
      input  exu_ready, cdb_valid, cdb_tag, cdb_rob_idx, cdb_data, cdb_ch, fifo_cnt
   );

   modport slave (
      input  exu_valid, exu_tag, exu_rob_idx, exu_data, flush,
      output exu_ready, cdb_valid, cdb_tag, cdb_rob_idx, cdb_data, cdb_ch, fifo_cnt
   );
endinterface

// File: rtl/cdb_arb.sv
// cdb_arb
//   Common-data-bus arbiter. Each of NUM_CH execution units owns a small
//   completion FIFO; every cycle at most one FIFO head is granted onto the
//   registered CDB (round-robin when PRIO_MODE=0, fixed priority with
//   channel 0 highest when PRIO_MODE=1).
//
//   Ports
//     clk   clock
//     rst   synchronous active-low reset
//     bus   cdb_arb_if.slave: execution-unit channels, flush, CDB, fifo_cnt
//
//   Priority of control: reset > flush > normal operation.
module cdb_arb #(
   parameter int NUM_CH     = 4,
   parameter int TAG_W      = 4,
   parameter int ROB_IDX_W  = 5,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2,
   parameter int PRIO_MODE  = 0
) (
   input logic      clk,
   input logic      rst,
   cdb_arb_if.slave bus
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int ENT_W = TAG_W + ROB_IDX_W + DATA_W;

   logic [ENT_W-1:0] mem [NUM_CH][FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr [NUM_CH];
   logic [PTR_W-1:0] wr_ptr [NUM_CH];
   logic [CNT_W-1:0] cnt [NUM_CH];
   logic [CH_W-1:0]  rr_ptr;

   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] ready;
   logic [NUM_CH-1:0] push;
   logic [NUM_CH-1:0] pop;
   logic              gnt_valid;
   logic [CH_W-1:0]   gnt_ch;
   logic [ENT_W-1:0]  head;

   // Ready is purely from registered occupancy plus flush/rst, so a full FIFO
   // that pops this cycle only re-opens on the following cycle.
   always_comb begin
      ready = '0;
      req   = '0;
      push  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ready[i] = (cnt[i] < CNT_W'(FIFO_DEPTH)) && !bus.flush && rst;
         req[i]   = (cnt[i] != '0);
         push[i]  = bus.exu_valid[i] && ready[i];
      end
   end

   assign bus.exu_ready = ready;

   // Arbitration on FIFO heads. Both scans run downward with the last hit
   // winning, which yields the first requester at or after the start point.
   always_comb begin
      logic [CH_W-1:0] idx;
      gnt_valid = 1'b0;
      gnt_ch    = '0;
      idx       = '0;
      if (PRIO_MODE == 1) begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
               gnt_valid = 1'b1;
               gnt_ch    = CH_W'(i);
            end
         end
      end else begin
         for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
            if (req[idx]) begin
               gnt_valid = 1'b1;
               gnt_ch    = idx;
            end
         end
      end
   end

   // No pop is taken in a flush cycle; the flush empties everything anyway.
   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         pop[i] = gnt_valid && (gnt_ch == CH_W'(i)) && !bus.flush;
      end
   end

   assign head = mem[gnt_ch][rd_ptr[gnt_ch]];

   always_comb begin
      bus.fifo_cnt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         bus.fifo_cnt[i*CNT_W +: CNT_W] = cnt[i];
      end
   end

   // Storage needs no reset: push is already blocked by reset and flush.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (push[i]) begin
            mem[i][wr_ptr[i]] <= {bus.exu_tag[i*TAG_W +: TAG_W],
                                  bus.exu_rob_idx[i*ROB_IDX_W +: ROB_IDX_W],
                                  bus.exu_data[i*DATA_W +: DATA_W]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]    <= '0;
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
         end
         rr_ptr          <= '0;
         bus.cdb_valid   <= 1'b0;
         bus.cdb_tag     <= '0;
         bus.cdb_rob_idx <= '0;
         bus.cdb_data    <= '0;
         bus.cdb_ch      <= '0;
      end else if (bus.flush) begin
         // Payload registers keep their last values; only the strobe drops.
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]    <= '0;
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
         end
         rr_ptr        <= '0;
         bus.cdb_valid <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
               wr_ptr[i] <= (wr_ptr[i] == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr[i] + PTR_W'(1);
            end
            if (pop[i]) begin
               rd_ptr[i] <= (rd_ptr[i] == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr[i] + PTR_W'(1);
            end
            case ({push[i], pop[i]})
               2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
               2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
               default: cnt[i] <= cnt[i];
            endcase
         end
         bus.cdb_valid <= gnt_valid;
         if (gnt_valid) begin
            {bus.cdb_tag, bus.cdb_rob_idx, bus.cdb_data} <= head;
            bus.cdb_ch <= gnt_ch;
            if (PRIO_MODE == 0) begin
               rr_ptr <= (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
            end
         end
      end
   end
endmodule

// File: doc/cdb_arb.md
Name: cdb_arb

Overview:
- Parametrised common-data-bus arbiter for the out-of-order core.
- Sits between NUM_CH execution units (alu, mdu, lsu, and future units) and the single CDB that feeds the reservation stations, rfu and rob.
- Each channel has its own completion FIFO, so an execution unit retires a result without waiting for the bus.
- One result per cycle is granted onto a registered CDB, using a round-robin or fixed-priority policy.

Parameters:
- NUM_CH, 4, number of execution-unit channels (2..8).
- TAG_W, 4, reservation-station tag width.
- ROB_IDX_W, 5, rob index width.
- DATA_W, 32, result width.
- FIFO_DEPTH, 2, entries per channel FIFO (power of two, 1..8).
- PRIO_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority with channel 0 highest.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- exu_valid  in  NUM_CH  per-channel result valid
- exu_ready  out  NUM_CH  per-channel FIFO can accept a result
- exu_tag  in  NUM_CH*TAG_W  per-channel tag; channel i occupies bits [i*TAG_W +: TAG_W]
- exu_rob_idx  in  NUM_CH*ROB_IDX_W  per-channel rob index, packed the same way
- exu_data  in  NUM_CH*DATA_W  per-channel result, packed the same way
- flush  in  1  mispredict flush; discards all buffered results
- cdb_valid  out  1  CDB broadcast valid (registered)
- cdb_tag  out  TAG_W  broadcast tag
- cdb_rob_idx  out  ROB_IDX_W  broadcast rob index
- cdb_data  out  DATA_W  broadcast result
- cdb_ch  out  max(1,$clog2(NUM_CH))  source channel of the current broadcast
- fifo_cnt  out  NUM_CH*($clog2(FIFO_DEPTH)+1)  per-channel occupancy, for debug and perf

Behaviour:
- Reset (rst==0 at a clk edge):
  - All FIFOs empty; round-robin pointer = 0.
  - cdb_valid = 0; cdb_tag, cdb_rob_idx, cdb_data and cdb_ch = 0; fifo_cnt = 0.
  - exu_ready is forced to 0 while rst==0.
  - A reset in the middle of traffic drops every buffered entry with no broadcast.
- Channel handshake:
  - exu_ready[i] = (cnt[i] < FIFO_DEPTH) && !flush && rst. It depends only on registered state plus flush and rst, never on exu_valid.
  - A push happens on a clk edge where exu_valid[i] && exu_ready[i].
  - A full FIFO does not accept a push in the same cycle as its pop. exu_ready rises the cycle after the pop.
  - Results with exu_valid high and exu_ready low are held by the producer, not lost.
- FIFO:
  - Circular, with rd_ptr and wr_ptr that wrap modulo FIFO_DEPTH.
  - cnt is updated by +1 on push, -1 on pop, 0 change on both or neither.
- Arbitration (combinational, on FIFO heads):
  - The request vector is cnt[i] != 0.
  - PRIO_MODE 0: grant the first requester at or after rr_ptr, scanning upward and wrapping. After a grant to channel k, rr_ptr = (k+1) mod NUM_CH. With no grant, rr_ptr holds.
  - PRIO_MODE 1: grant the lowest-index requester; rr_ptr is unused.
  - At most one grant per cycle.
- CDB register:
  - On the grant edge, the head of the granted FIFO is popped and loaded into the cdb_* registers. cdb_valid = 1 for exactly one cycle per grant.
  - With no grant, cdb_valid = 0 and the data registers hold their last values.
  - Latency: a push at edge E0 is broadcast, at the earliest, during the cycle after edge E1 (one cycle in the FIFO).
  - The CDB has no backpressure.
- Empty channel: never granted. If all channels are empty, cdb_valid = 0 next cycle.
- Flush (flush==1 at an edge):
  - All FIFOs are emptied (cnt = 0, pointers = 0) and rr_ptr = 0.
  - cdb_valid = 0 in the following cycle; no grant is taken in the flush cycle.
  - Pushes are blocked because exu_ready is 0.
  - Priority: reset > flush > normal operation.
- Ordering: per-channel FIFO order is preserved. There is no ordering guarantee across channels.

Test Plan:
- Reset, then idle for 5 cycles -> cdb_valid=0, exu_ready=4'b1111, fifo_cnt all 0. With rst=0 held for 3 cycles -> exu_ready=4'b0000.
- Single push on ch2 (tag=4'h6, rob=5'd9, data=32'hDEAD_BEEF) at edge E0 -> during the cycle after E1: cdb_valid=1, cdb_ch=2, and tag/rob/data match. Next cycle cdb_valid=0.
- PRIO_MODE 0: all 4 channels push in the same cycle, one entry each -> broadcasts on 4 consecutive cycles in order ch0, ch1, ch2, ch3. rr_ptr then equals 0, and a second round also starts at ch0.
- PRIO_MODE 1: ch0 pushes back-to-back continuously while ch3 holds one entry -> ch3 is never granted while ch0 is non-empty. It is granted the first cycle ch0 is empty.
- FIFO_DEPTH=2: ch1 pushes 3 results while ch0 streams continuously in PRIO_MODE 1 -> exu_ready[1]=0 after 2 pushes and the third result is held. After ch0 drains, ch1 results come out in push order with no loss or duplication.
- Two entries are buffered in each of ch0 and ch1, then flush pulses for 1 cycle -> fifo_cnt all 0 and no stale broadcast. A fresh push on ch1 afterwards is broadcast with rr_ptr restarted at 0.
